// File: rtl/reset_seq_pkg.sv
// Shared types and polarity helpers for the reset sequencer and its users.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STAGGER = 2'd1,
        DONE    = 2'd2
    } seq_state_e;

    function automatic logic asserted_level(input int active_high);
        return (active_high != 0);
    endfunction

    function automatic logic released_level(input int active_high);
        return (active_high == 0);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Asynchronous-assert, synchronous-deassert reset synchroniser, STAGES flops deep.
module reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic arst_n_i,
    output logic rst_sync_n_o
);

    if (STAGES < 2) begin : g_bad_stages
        $error("reset_sync: STAGES must be at least 2");
    end

    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on reset generator: holds NUM_CH resets, then releases them one by one.
// Optional macro RESET_SEQUENCER_SOFT_REQ_EN adds a soft_req input that replays the sequence from DONE.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int CNT_W           = 8,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGGER_CYCLES  = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int OUT_ACTIVE_HIGH = 1
) (
    input  logic              clk,
    input  logic              reset_n,
`ifdef RESET_SEQUENCER_SOFT_REQ_EN
    input  logic              soft_req,
`endif
    output logic [NUM_CH-1:0] reset_out,
    output logic              ready
);

    localparam int CH_W = $clog2(NUM_CH) + 1;

    localparam logic              ASSERT_LVL  = asserted_level(OUT_ACTIVE_HIGH);
    localparam logic              RELEASE_LVL = released_level(OUT_ACTIVE_HIGH);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STAG_LAST   = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CH_W-1:0]   CH_ONE      = CH_W'(1);
    localparam logic [CH_W-1:0]   CH_LAST     = CH_W'(NUM_CH - 1);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("reset_sequencer: NUM_CH must be in 1..16");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_hold
        $error("reset_sequencer: HOLD_CYCLES out of range for CNT_W");
    end
    if (STAGGER_CYCLES < 1 || STAGGER_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_stagger
        $error("reset_sequencer: STAGGER_CYCLES out of range for CNT_W");
    end
    if (OUT_ACTIVE_HIGH != 0 && OUT_ACTIVE_HIGH != 1) begin : g_bad_polarity
        $error("reset_sequencer: OUT_ACTIVE_HIGH must be 0 or 1");
    end

    logic rst_sync_n;

    reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk          (clk),
        .arst_n_i     (reset_n),
        .rst_sync_n_o (rst_sync_n)
    );

    seq_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CH_W-1:0]    ch_idx_q;
    logic [NUM_CH-1:0]  reset_out_q;
    logic               ready_q;

    // The synchronised reset asserts as soon as reset_n falls, so no clock is needed to assert outputs.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            ch_idx_q    <= '0;
            reset_out_q <= {NUM_CH{ASSERT_LVL}};
            ready_q     <= 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        reset_out_q[0] <= RELEASE_LVL;
                        cnt_q          <= '0;
                        ch_idx_q       <= CH_ONE;
                        if (NUM_CH == 1) begin
                            state_q <= DONE;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= STAGGER;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STAGGER: begin
                    if (cnt_q == STAG_LAST) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (ch_idx_q == CH_W'(i)) begin
                                reset_out_q[i] <= RELEASE_LVL;
                            end
                        end
                        cnt_q    <= '0;
                        ch_idx_q <= ch_idx_q + CH_ONE;
                        if (ch_idx_q == CH_LAST) begin
                            state_q <= DONE;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DONE: begin
`ifdef RESET_SEQUENCER_SOFT_REQ_EN
                    if (soft_req) begin
                        state_q     <= HOLD;
                        cnt_q       <= '0;
                        ch_idx_q    <= '0;
                        reset_out_q <= {NUM_CH{ASSERT_LVL}};
                        ready_q     <= 1'b0;
                    end
`else
                    state_q <= DONE;
`endif
                end
                default: begin
                    state_q     <= HOLD;
                    cnt_q       <= '0;
                    ch_idx_q    <= '0;
                    reset_out_q <= {NUM_CH{ASSERT_LVL}};
                    ready_q     <= 1'b0;
                end
            endcase
        end
    end

    assign reset_out = reset_out_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default, low-polarity single-channel and long-hold instances.
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
`ifdef RESET_SEQUENCER_SOFT_REQ_EN
    logic soft_req = 1'b0;
`endif

    logic [3:0] out_def;
    logic       rdy_def;
    logic [0:0] out_low;
    logic       rdy_low;
    logic [2:0] out_long;
    logic       rdy_long;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    reset_sequencer dut_def (
        .clk       (clk),
        .reset_n   (reset_n),
`ifdef RESET_SEQUENCER_SOFT_REQ_EN
        .soft_req  (soft_req),
`endif
        .reset_out (out_def),
        .ready     (rdy_def)
    );

    reset_sequencer #(
        .NUM_CH (1), .HOLD_CYCLES (1), .OUT_ACTIVE_HIGH (0)
    ) dut_low (
        .clk       (clk),
        .reset_n   (reset_n),
`ifdef RESET_SEQUENCER_SOFT_REQ_EN
        .soft_req  (soft_req),
`endif
        .reset_out (out_low),
        .ready     (rdy_low)
    );

    reset_sequencer #(
        .NUM_CH (3), .CNT_W (8), .HOLD_CYCLES (255), .STAGGER_CYCLES (1)
    ) dut_long (
        .clk       (clk),
        .reset_n   (reset_n),
`ifdef RESET_SEQUENCER_SOFT_REQ_EN
        .soft_req  (soft_req),
`endif
        .reset_out (out_long),
        .ready     (rdy_long)
    );

    // Expected outputs e edges after reset_n rose; channel i releases at edge 2+hold+i*stag.
    function automatic logic [15:0] exp_out(input int e, input int nch, input int hold,
                                            input int stag, input bit ah);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < nch; i++) begin
            if (e < 2 + hold + i * stag) v[i] = ah;
            else                         v[i] = !ah;
        end
        return v;
    endfunction

    function automatic logic exp_rdy(input int e, input int nch, input int hold, input int stag);
        return (e >= 2 + hold + (nch - 1) * stag);
    endfunction

    task automatic test_reset();
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (out_def !== 4'hF) begin
            n_errors++; $display("FAIL reset_def_out got %h expected %h", out_def, 4'hF);
        end
        n_checks++;
        if (rdy_def !== 1'b0) begin
            n_errors++; $display("FAIL reset_def_ready got %b expected 0", rdy_def);
        end
        n_checks++;
        if (out_low !== 1'b0) begin
            n_errors++; $display("FAIL reset_low_out got %b expected 0", out_low);
        end
        n_checks++;
        if (rdy_low !== 1'b0) begin
            n_errors++; $display("FAIL reset_low_ready got %b expected 0", rdy_low);
        end
        n_checks++;
        if (out_long !== 3'h7) begin
            n_errors++; $display("FAIL reset_long_out got %h expected 7", out_long);
        end
        n_checks++;
        if (rdy_long !== 1'b0) begin
            n_errors++; $display("FAIL reset_long_ready got %b expected 0", rdy_long);
        end
    endtask

    task automatic test_power_up();
        logic [15:0] got, exp;
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 262; e++) begin
            @(posedge clk);
            #1;
            got = 16'(out_def); exp = exp_out(e, 4, 16, 4, 1'b1);
            n_checks++;
            if (got !== exp || rdy_def !== exp_rdy(e, 4, 16, 4)) begin
                n_errors++;
                $display("FAIL pwr_def e=%0d out=%h rdy=%b expected out=%h rdy=%b",
                         e, got, rdy_def, exp, exp_rdy(e, 4, 16, 4));
            end
            got = 16'(out_low); exp = exp_out(e, 1, 1, 4, 1'b0);
            n_checks++;
            if (got !== exp || rdy_low !== exp_rdy(e, 1, 1, 4)) begin
                n_errors++;
                $display("FAIL pwr_low e=%0d out=%h rdy=%b expected out=%h rdy=%b",
                         e, got, rdy_low, exp, exp_rdy(e, 1, 1, 4));
            end
            got = 16'(out_long); exp = exp_out(e, 3, 255, 1, 1'b1);
            n_checks++;
            if (got !== exp || rdy_long !== exp_rdy(e, 3, 255, 1)) begin
                n_errors++;
                $display("FAIL pwr_long e=%0d out=%h rdy=%b expected out=%h rdy=%b",
                         e, got, rdy_long, exp, exp_rdy(e, 3, 255, 1));
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] got, exp;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        n_checks++;
        if (out_def !== 4'hC) begin
            n_errors++; $display("FAIL mid_pre_out got %h expected c", out_def);
        end
        reset_n = 1'b0;
        #2;
        n_checks++;
        if (out_def !== 4'hF || rdy_def !== 1'b0) begin
            n_errors++; $display("FAIL mid_async_def out=%h rdy=%b expected out=f rdy=0", out_def, rdy_def);
        end
        n_checks++;
        if (out_low !== 1'b0 || out_long !== 3'h7) begin
            n_errors++; $display("FAIL mid_async_other low=%b long=%h expected low=0 long=7", out_low, out_long);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk);
            #1;
            got = 16'(out_def); exp = exp_out(e, 4, 16, 4, 1'b1);
            n_checks++;
            if (got !== exp || rdy_def !== exp_rdy(e, 4, 16, 4)) begin
                n_errors++;
                $display("FAIL mid_replay e=%0d out=%h rdy=%b expected out=%h rdy=%b",
                         e, got, rdy_def, exp, exp_rdy(e, 4, 16, 4));
            end
            got = 16'(out_low); exp = exp_out(e, 1, 1, 4, 1'b0);
            n_checks++;
            if (got !== exp || rdy_low !== exp_rdy(e, 1, 1, 4)) begin
                n_errors++;
                $display("FAIL mid_replay_low e=%0d out=%h rdy=%b expected out=%h", e, got, rdy_low, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [15:0] got, exp;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_def !== 4'hF || rdy_def !== 1'b0) begin
            n_errors++; $display("FAIL glitch_async out=%h rdy=%b expected out=f rdy=0", out_def, rdy_def);
        end
        #2;
        reset_n = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk);
            #1;
            got = 16'(out_def); exp = exp_out(e, 4, 16, 4, 1'b1);
            n_checks++;
            if (got !== exp || rdy_def !== exp_rdy(e, 4, 16, 4)) begin
                n_errors++;
                $display("FAIL glitch_replay e=%0d out=%h rdy=%b expected out=%h rdy=%b",
                         e, got, rdy_def, exp, exp_rdy(e, 4, 16, 4));
            end
        end
    endtask

`ifdef RESET_SEQUENCER_SOFT_REQ_EN
    task automatic test_soft_req();
        logic [15:0] got, exp;
        @(negedge clk);
        soft_req = 1'b1;
        @(posedge clk);
        #1;
        soft_req = 1'b0;
        n_checks++;
        if (out_def !== 4'hF || rdy_def !== 1'b0) begin
            n_errors++; $display("FAIL soft_assert out=%h rdy=%b expected out=f rdy=0", out_def, rdy_def);
        end
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            got = 16'(out_def); exp = exp_out(k + 2, 4, 16, 4, 1'b1);
            n_checks++;
            if (got !== exp || rdy_def !== exp_rdy(k + 2, 4, 16, 4)) begin
                n_errors++;
                $display("FAIL soft_replay k=%0d out=%h rdy=%b expected out=%h rdy=%b",
                         k, got, rdy_def, exp, exp_rdy(k + 2, 4, 16, 4));
            end
            if (k == 21) soft_req = 1'b1;
            if (k == 22) soft_req = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_power_up();
        test_mid_reset();
        test_glitch();
`ifdef RESET_SEQUENCER_SOFT_REQ_EN
        test_soft_req();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
